mdu_iter: RTL and testbench

// - Multi-cycle multiply/divide unit producing the 64-bit {HI,LO} result consumed by the HI/LO register file.
// - Executes MULT/MULTU in 2 cycles and DIV/DIVU as a 32-iteration radix-2 restoring divide.
// - Sits in EX beside the ALU. busy stalls the pipeline; done drives HiloWrite with HiloSrc=0.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_div_step.sv | 26 ++
 rtl/mdu_iter.sv | 126 ++++++++++++
 tb/tb_mdu_iter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational radix-2 restoring division step on magnitudes.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] trial;

    // rem < divisor always holds, so a set MSB of the trial means borrow
    always_comb begin
        trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MIPS multiply/divide unit: 2-cycle multiply, 32-step restoring divide,
// producing {HI,LO} with a one-cycle done pulse.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] MDUResult
);

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             sign_q;
    logic             sign_r;
    logic             dz;
    logic [CNT_W-1:0] count;

    logic               in_signed;
    logic               in_div;
    logic               b_zero;
    logic [2*WIDTH-1:0] mul_s;
    logic [2*WIDTH-1:0] mul_u;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    assign in_signed = ~op[0];
    assign in_div    = op[1];
    assign b_zero    = (src_b == '0);
    assign busy      = (state != S_IDLE);

    // Sign-extending both operands to 2*WIDTH gives the two's-complement product mod 2^(2*WIDTH)
    assign mul_s = {{WIDTH{a_r[WIDTH-1]}}, a_r} * {{WIDTH{b_r[WIDTH-1]}}, b_r};
    assign mul_u = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (b_r),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_r      <= OP_MULT;
            a_r       <= '0;
            b_r       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz        <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
            MDUResult <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            op_r   <= op_t'(op);
                            a_r    <= src_a;
                            b_r    <= in_div ? neg_if(src_b, in_signed & src_b[WIDTH-1]) : src_b;
                            quo_r  <= neg_if(src_a, in_div & in_signed & src_a[WIDTH-1]);
                            rem_r  <= '0;
                            count  <= '0;
                            sign_q <= in_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            sign_r <= in_signed & src_a[WIDTH-1];
                            dz     <= in_div & b_zero;
                            if (!in_div)
                                state <= S_MUL;
                            else if (b_zero)
                                state <= S_FIX;
                            else
                                state <= S_DIV;
                        end
                    end
                    S_MUL: begin
                        MDUResult <= (op_r == OP_MULT) ? mul_s : mul_u;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                    S_DIV: begin
                        rem_r <= rem_nx;
                        quo_r <= quo_nx;
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(DIV_STEPS - 1))
                            state <= S_FIX;
                    end
                    S_FIX: begin
                        // Divide by zero returns the dividend in HI and all ones in LO, no trap
                        if (dz)
                            MDUResult <= {a_r, {WIDTH{1'b1}}};
                        else
                            MDUResult <= {neg_if(rem_r, sign_r), neg_if(quo_r, sign_q)};
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed ops push expected {HI,LO} and done cycle,
// a negedge monitor pops and compares whenever done is presented.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [63:0] MDUResult;

    mdu_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .MDUResult (MDUResult)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && done) begin
            exp_t e;
            check("done_while_busy", busy, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", done, 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, MDUResult, e.res);
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
    end

    // Called at a negedge; drives start for one cycle, returns at the next negedge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input bit push, input string name);
        exp_t e;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (push) begin
            e.res  = exp;
            e.due  = cyc + lat;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 64'd0);
        check("reset_done", done, 64'd0);
        check("reset_result", MDUResult, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 2, 1, "mult_m3x5");
        check("mult_busy_t1", busy, 64'd1);
        @(negedge clk);
        check("mult_busy_t2", busy, 64'd0);

        // Issued in the MULT done cycle
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 2, 1, "multu_max");
        wait_cycles(1);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 1, "div_m7d2");
        wait_cycles(3);
        start = 1'b1; op = OP_MULT; src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(29);
        issue(OP_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1, "divu_100d7");
        wait_cycles(33);
        issue(OP_DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 2, 1, "divu_dz");
        wait_cycles(1);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34, 1, "div_ovf");
        wait_cycles(33);
        issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 2, 1, "div_dz");
        wait_cycles(1);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34, 1, "div_7dm2");
        wait_cycles(33);
        issue(OP_MULT, 32'h8000_0000, 32'd2, 64'hFFFFFFFF_00000000, 2, 1, "mult_min2");
        wait_cycles(1);
        issue(OP_MULTU, 32'h8000_0000, 32'd2, 64'h00000001_00000000, 2, 1, "multu_min2");
        wait_cycles(1);

        issue(OP_DIV, 32'd50, 32'd3, 64'd0, 34, 0, "div_flushed");
        wait_cycles(9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 64'd0);
        issue(OP_MULT, 32'd2, 32'd3, 64'd6, 2, 1, "mult_2x3");
        wait_cycles(2);

        flush = 1'b1; start = 1'b1; op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_start_drop", busy, 64'd0);

        issue(OP_MULT, 32'd7, 32'd7, 64'd0, 2, 0, "mult_flushed");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_mul_done", done, 64'd0);
        check("flush_mul_hold", MDUResult, 64'd6);

        issue(OP_DIVU, 32'd1000, 32'd3, 64'd0, 34, 0, "div_reset");
        wait_cycles(4);
        rst = 1'b0;
        #1;
        check("midop_reset_busy", busy, 64'd0);
        check("midop_reset_done", done, 64'd0);
        check("midop_reset_result", MDUResult, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(40);
        check("post_reset_busy", busy, 64'd0);

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drain", sb.size(), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
